// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and default parameters for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] below;
  logic [2*NREQ-1:0] masked;
  assign below = (NREQ'(1) << ptr) - NREQ'(1);
  assign masked = {req, req & ~below};
  assign any = |req;
  // lowest set bit of the doubled, masked vector is the wrapped winner
  always_comb begin
    idx = '0;
    for (int j = 2*NREQ-1; j >= 0; j--) if (masked[j]) idx = IW'(j % NREQ);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(MAX_BURST+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [DW-1:0]    fifo_din,
  output logic [IW-1:0]    grant_id,
  output logic             busy
);
  arb_state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic [CW-1:0] beat_cnt;
  logic pick_any, owner_valid, beat, done;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );
  // owner datapath and next state; a beat moves only while bursting and the FIFO has room
  always_comb begin
    busy = state == BURST;
    owner_valid = req_valid[grant_id];
    beat = busy && owner_valid && !fifo_full;
    done = beat && (req_last[grant_id] || beat_cnt + CW'(1) == CW'(MAX_BURST));
    fifo_wr = beat && rst_n;
    req_ready = beat ? NREQ'(1) << grant_id : '0;
    fifo_din = (busy && owner_valid) ? req_data[int'(grant_id)*DW +: DW] : '0;
    state_nxt = (state == IDLE) ? (pick_any ? BURST : IDLE) : (done ? IDLE : BURST);
  end
  // state, grant, beat count and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end
      if (beat) beat_cnt <= beat_cnt + CW'(1);
      if (done) rr_ptr <= (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tests against a queue-based arbitration model and a bench FIFO
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_full = 1'b0;
  logic fifo_wr, busy;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] fifo_din;
  logic [1:0] grant_id;
  logic [8:0] srcq [N][$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc = '0;
  logic [7:0] fq [$];
  logic [7:0] wlog [$];
  int wcyc [$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  fifo_wr_arbiter #(.NREQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_din(fifo_din),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // bench FIFO full flag is registered, like the real FIFO's
  always @(posedge clk) fifo_full <= fq.size() >= 16;

  // model: idle picks first valid requester scanning from the pointer; bursts end on last or cap
  always @(negedge clk) begin
    logic e_busy, e_beat;
    int o;
    cyc++;
    if (!rst_n) begin
      chk("wr_in_reset", fifo_wr, 0);
      m_owner = -1;
      m_ptr = 0;
      m_cnt = 0;
      acc = '0;
    end else begin
      e_busy = m_owner >= 0;
      o = e_busy ? m_owner : 0;
      e_beat = e_busy && req_valid[o] && !fifo_full;
      chk("busy", busy, e_busy);
      chk("fifo_wr", fifo_wr, e_beat);
      chk("req_ready", req_ready, e_beat ? (1 << o) : 0);
      chk("fifo_din", fifo_din, (e_busy && req_valid[o]) ? req_data[o*DW +: DW] : 0);
      if (e_busy) chk("grant_id", grant_id, o);
      acc = req_ready;
      if (fifo_wr && fq.size() < 16) begin
        fq.push_back(fifo_din);
        wlog.push_back(fifo_din);
        wcyc.push_back(cyc);
      end
      if (!e_busy) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_cnt = 0;
      end else if (e_beat) begin
        m_cnt++;
        if (req_last[o] || m_cnt == MB) begin
          m_ptr = (o + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = srcq[i].size() > 0 && !hold[i];
      req_last[i] = srcq[i].size() > 0 && srcq[i][0][8];
      req_data[i*DW +: DW] = srcq[i].size() > 0 ? srcq[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain();
    int n = 0;
    while ((pending() || busy) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", n < 200, 1);
  endtask

  task automatic wait_writes(input int cnt);
    int n = 0;
    while (wlog.size() < cnt && n < 50) begin
      tick();
      n++;
    end
    chk("write_count", wlog.size(), cnt);
  endtask

  task automatic check_log(input string name, input logic [7:0] e [$]);
    chk({name, "_len"}, wlog.size(), e.size());
    for (int k = 0; k < e.size(); k++) if (k < wlog.size()) chk(name, wlog[k], e[k]);
  endtask

  task automatic new_test();
    wlog.delete();
    wcyc.delete();
    fq.delete();
    fifo_full = 1'b0;
  endtask

  initial begin
    logic [7:0] e [$];
    for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'h10 + 8'(i)});
    srcq[0].push_back({1'b1, 8'h10});
    drive();
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("first_busy", busy, 1);
    chk("first_gid", grant_id, 0);
    drain();
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    check_log("rr", e);
    for (int k = 1; k < wcyc.size(); k++) chk("rr_gap", wcyc[k] - wcyc[k-1], 2);

    new_test();
    for (int k = 0; k < 6; k++) srcq[2].push_back({k == 5, 8'hA0 + 8'(k)});
    srcq[3].push_back({1'b1, 8'h33});
    drive();
    drain();
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h33, 8'hA4, 8'hA5};
    check_log("cap", e);

    new_test();
    for (int k = 0; k < 16; k++) fq.push_back(8'hEE);
    fifo_full = 1'b1;
    srcq[1].push_back({1'b1, 8'h55});
    drive();
    tick();
    chk("full_busy", busy, 1);
    chk("full_gid", grant_id, 1);
    repeat (3) begin
      tick();
      chk("full_wr", fifo_wr, 0);
      chk("full_ready1", req_ready[1], 0);
    end
    void'(fq.pop_front());
    fifo_full = 1'b0;
    #1;
    chk("unfull_wr", fifo_wr, 1);
    chk("unfull_din", fifo_din, 8'h55);
    drain();
    e = '{8'h55};
    check_log("full", e);
    chk("fifo_level", fq.size(), 16);
    chk("fifo_tail", fq[15], 8'h55);

    new_test();
    srcq[0].push_back({1'b0, 8'hB0});
    srcq[0].push_back({1'b1, 8'hB1});
    srcq[1].push_back({1'b1, 8'hC1});
    drive();
    wait_writes(1);
    hold[0] = 1'b1;
    drive();
    repeat (3) begin
      #1;
      chk("gap_busy", busy, 1);
      chk("gap_gid", grant_id, 0);
      chk("gap_ready", req_ready, 0);
      tick();
    end
    hold[0] = 1'b0;
    drive();
    drain();
    e = '{8'hB0, 8'hB1, 8'hC1};
    check_log("gap", e);

    new_test();
    for (int k = 0; k < 4; k++) srcq[2].push_back({k == 3, 8'hD0 + 8'(k)});
    drive();
    wait_writes(2);
    rst_n = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_wr", fifo_wr, 0);
    rst_n = 1'b1;
    srcq[0].push_back({1'b1, 8'hE0});
    drive();
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_gid", grant_id, 0);
    drain();
    e = '{8'hD0, 8'hD1, 8'hE0, 8'hD2, 8'hD3};
    check_log("mid", e);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
